// File: rtl/adder3_writeback.sv
// Writeback stage for the 24-bit modular adder/subtractor: buffers results in a
// 2-entry FIFO, range-checks them and streams them to coefficient RAM.
module adder3_writeback #(
  parameter int ADDR_W = 8,
  parameter int LEN_K  = 128,
  parameter int LEN_D  = 256,
  parameter int KQ     = 3329,
  parameter int DQ     = 8380417
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  input  logic [23:0]       in_data,
  output logic              in_ready,
  input  logic              mem_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              range_err
);

  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic              r_mode;
  logic [ADDR_W-1:0] r_base;
  logic [CNT_W-1:0]  r_acc_cnt;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_range_err;

  logic [23:0]       r_fifo [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic [CNT_W-1:0]  w_len;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_bad;
  logic [CNT_W-1:0]  w_acc_next;
  logic [CNT_W-1:0]  w_wr_next;

  assign w_len   = r_mode ? CNT_W'(LEN_D) : CNT_W'(LEN_K);
  assign w_full  = (r_count == 2'd2);
  assign w_empty = (r_count == 2'd0);

  // Full blocks acceptance even when a pop is pending this cycle.
  assign in_ready = (r_state == S_RUN) && !w_full && (r_acc_cnt < w_len);
  assign w_push   = in_valid && in_ready;

  assign wr_en   = ((r_state == S_RUN) || (r_state == S_DRAIN)) && !w_empty && mem_ready;
  assign w_pop   = wr_en;
  assign wr_data = r_fifo[r_rd_ptr];
  assign wr_addr = r_base + r_wr_cnt[ADDR_W-1:0];

  assign w_acc_next = r_acc_cnt + CNT_W'(w_push);
  assign w_wr_next  = r_wr_cnt + CNT_W'(w_pop);

  // Kyber packs two independent 12-bit lanes; each must be reduced on its own.
  assign w_bad = r_mode ? (32'(in_data) >= DQ)
                        : ((32'(in_data[23:12]) >= KQ) || (32'(in_data[11:0]) >= KQ));

  assign busy      = r_busy;
  assign done      = r_done;
  assign range_err = r_range_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_base      <= '0;
      r_acc_cnt   <= '0;
      r_wr_cnt    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mode      <= mode;
            r_base      <= base_addr;
            r_acc_cnt   <= '0;
            r_wr_cnt    <= '0;
            r_range_err <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc_cnt <= w_acc_next;
          r_wr_cnt  <= w_wr_next;
          if (w_push && w_bad) begin
            r_range_err <= 1'b1;
          end
          if (w_acc_next == w_len) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_wr_cnt <= w_wr_next;
          // Last word always leaves from here: no bypass, so the final push pops later.
          if (w_wr_next == w_len) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= in_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

endmodule

// File: tb/tb_adder3_writeback.sv
// Scoreboard bench for adder3_writeback: expected (addr, data) pairs are queued on
// acceptance and retired against RAM writes.
module tb_adder3_writeback;

  localparam int KQ = 3329;
  localparam int DQ = 8380417;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  base_addr = 8'd0;
  logic        in_valid = 1'b0;
  logic [23:0] in_data = 24'd0;
  logic        mem_ready = 1'b1;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [23:0] wr_data;
  logic        busy;
  logic        done;
  logic        range_err;

  adder3_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .base_addr (base_addr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_ready (mem_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_in_pass = 0;
  int last_wr_cyc = -10;
  int done_cnt = 0;
  int exp_len = 0;
  logic [31:0] sb[$];
  logic [23:0] words [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input bit m, input logic [23:0] d);
    if (m) return int'(d) >= DQ;
    return (int'(d[23:12]) >= KQ) || (int'(d[11:0]) >= KQ);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && wr_en) begin
      if (sb.size() == 0) begin
        check("wr_extra", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e[31:24]));
        check("wr_data", 32'(wr_data), 32'(e[23:0]));
      end
      wr_in_pass++;
      last_wr_cyc = cyc;
    end
    if (rst && done) begin
      done_cnt++;
      check("done_lat", cyc, last_wr_cyc + 1);
      check("done_wr_total", wr_in_pass, exp_len);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_range_err"}, 32'(range_err), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
  endtask

  task automatic run_pass(input bit m, input logic [7:0] base, input int len,
                          input int stall_after, input bit rnd, input bit inject,
                          input int abort_at);
    int acc = 0;
    int guard = 0;
    int stall_left = 0;
    int d0;
    bit err_exp = 1'b0;
    bit saw_block = 1'b0;
    @(posedge clk); #1;
    exp_len = len;
    wr_in_pass = 0;
    sb.delete();
    d0 = done_cnt;
    start = 1'b1;
    mode = m;
    base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    mode = ~m;
    base_addr = base ^ 8'h5A;
    check("busy_run", 32'(busy), 32'd1);
    check("err_clr", 32'(range_err), 32'd0);
    while (acc < len && guard < 5000) begin
      in_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data = words[acc];
      start = inject && (acc == 10);
      if (stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left--;
      end else begin
        mem_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      check("in_ready", 32'(in_ready), ((acc - wr_in_pass) < 2) ? 32'd1 : 32'd0);
      if (stall_after >= 0 && !in_ready && !mem_ready) saw_block = 1'b1;
      if (in_valid && in_ready) begin
        sb.push_back({base + 8'(acc), words[acc]});
        err_exp |= is_bad(m, words[acc]);
        acc++;
        if (acc == stall_after) stall_left = 5;
      end
      @(posedge clk); #1;
      guard++;
      if (acc == abort_at) break;
    end
    in_valid = 1'b0;
    start = 1'b0;
    mem_ready = 1'b1;
    if (abort_at >= 0) return;
    check("accepted", acc, len);
    if (stall_after >= 0) check("bp_block", 32'(saw_block), 32'd1);
    guard = 0;
    while (done_cnt == d0 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("done_seen", done_cnt - d0, 1);
    check("sb_empty", sb.size(), 0);
    check("wr_total", wr_in_pass, len);
    check("range_err", 32'(range_err), 32'(err_exp));
    check("busy_idle", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", done_cnt - d0, 1);
    $display("pass mode=%0d base=0x%0h len=%0d writes=%0d range_err=%0d", m, base, len,
             wr_in_pass, range_err);
  endtask

  initial begin
    #1;
    check_all_zero("rst");
    #20;
    rst = 1'b1;

    // Kyber full pass, lanes {i, i+1}
    for (int i = 0; i < 128; i++) words[i] = {12'(i), 12'(i + 1)};
    run_pass(1'b0, 8'h10, 128, -1, 1'b0, 1'b0, -1);

    // Dilithium pass wrapping past 0xFF, with a start injected mid-pass
    for (int i = 0; i < 256; i++) words[i] = 24'($urandom_range(0, DQ - 1));
    run_pass(1'b1, 8'hF0, 256, -1, 1'b0, 1'b1, -1);

    // Kyber backpressure after 3rd word, one lane equal to KQ
    for (int i = 0; i < 128; i++)
      words[i] = {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
    words[7] = 24'hD01000;
    run_pass(1'b0, 8'h20, 128, 3, 1'b0, 1'b0, -1);

    // Dilithium random handshakes, word equal to DQ and DQ-1
    for (int i = 0; i < 256; i++) words[i] = 24'($urandom_range(0, DQ - 1));
    words[100] = 24'h7FE001;
    words[101] = 24'h7FE000;
    run_pass(1'b1, 8'h00, 256, -1, 1'b1, 1'b0, -1);

    // Reset after 40 accepted words
    begin
      int d0;
      for (int i = 0; i < 128; i++)
        words[i] = {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
      words[5] = 24'hFFFFFF;
      run_pass(1'b0, 8'h40, 128, -1, 1'b0, 1'b0, 40);
      check("err_pre_rst", 32'(range_err), 32'd1);
      d0 = done_cnt;
      rst = 1'b0;
      #1;
      check_all_zero("abort");
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("no_done_abort", done_cnt - d0, 0);
      check("busy_abort", 32'(busy), 32'd0);
      $display("abort after 40 words, done pulses=%0d", done_cnt - d0);
    end

    // Fresh Kyber pass after abort, lanes at KQ-1
    for (int i = 0; i < 128; i++)
      words[i] = {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
    words[0] = 24'hD00D00;
    run_pass(1'b0, 8'h80, 128, -1, 1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

endmodule
